// File: rtl/casca_seq_if.sv
// Switch, PWM and status bundle between the board-level harness and casca_seq.
// The master side drives the raw switches and PWM sources; the slave side is the sequencer.
interface casca_seq_if;
    logic [2:0] sw_manual;
    logic       sw_seq;
    logic [2:0] sw_led;
    logic [2:0] pwm_in;
    logic [2:0] pwm_out;
    logic [2:0] en_out;
    logic [2:0] led;
    logic       step;
    logic [1:0] seq_state;

    modport master (
        output sw_manual, sw_seq, sw_led, pwm_in,
        input  pwm_out, en_out, led, step, seq_state
    );

    modport slave (
        input  sw_manual, sw_seq, sw_led, pwm_in,
        output pwm_out, en_out, led, step, seq_state
    );
endinterface

// File: rtl/casca_seq.sv
// Three-shell cascade sequencer: synchronises and debounces the board switches,
// steps S1->S2->S3 on a dwell timer and gates the per-shell PWM with the enable mask.
module casca_seq #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 100_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    casca_seq_if.slave   bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } seq_state_t;

    // Bit layout: [2:0] manual, [5:3] led, [6] seq
    logic [6:0]      raw_sw;
    logic [6:0]      sync_a;
    logic [6:0]      sync_b;
    logic [6:0]      stable;
    logic [DB_W-1:0] db_cnt [7];

    logic [2:0] manual_db;
    logic [2:0] led_db;
    logic       seq_db;

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [STEP_W-1:0]  timer;
    logic [STEP_W-1:0]  timer_nxt;
    logic               step_nxt;
    logic [2:0]         casc_en;

    logic [2:0] en_q;
    logic [2:0] pwm_q;
    logic [2:0] led_q;
    logic       step_q;

    assign raw_sw    = {bus.sw_seq, bus.sw_led, bus.sw_manual};
    assign manual_db = stable[2:0];
    assign led_db    = stable[5:3];
    assign seq_db    = stable[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw_sw;
            sync_b <= sync_a;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 7; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (sync_b[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            step_q <= step_nxt;
        end
    end

    // Dropping seq_db wins over a coincident dwell boundary, so abort never pulses step.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step_nxt  = 1'b0;
        if (state == IDLE) begin
            timer_nxt = '0;
            if (seq_db) begin
                state_nxt = S1;
                step_nxt  = 1'b1;
            end
        end else if (!seq_db) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else if (timer == STEP_LAST) begin
            timer_nxt = '0;
            step_nxt  = 1'b1;
            case (state)
                S1:      state_nxt = S2;
                S2:      state_nxt = S3;
                default: state_nxt = S1;
            endcase
        end else begin
            timer_nxt = timer + STEP_W'(1);
        end
    end

    always_comb begin
        casc_en = 3'b000;
        case (state)
            S1:      casc_en = 3'b001;
            S2:      casc_en = 3'b010;
            S3:      casc_en = 3'b100;
            default: casc_en = 3'b000;
        endcase
    end

    // PWM is gated by the enable mask already on the output, giving one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= '0;
            pwm_q <= '0;
            led_q <= '0;
        end else begin
            en_q  <= manual_db | casc_en;
            pwm_q <= bus.pwm_in & en_q;
            led_q <= led_db;
        end
    end

    assign bus.en_out    = en_q;
    assign bus.pwm_out   = pwm_q;
    assign bus.led       = led_q;
    assign bus.step      = step_q;
    assign bus.seq_state = state;
endmodule

// File: tb/tb_casca_seq.sv
// Directed bench for casca_seq with DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_casca_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [2:0] prev_en;
    logic [2:0] exp_en;

    casca_seq_if bus ();

    casca_seq #(
        .DEBOUNCE_CYCLES (4),
        .STEP_CYCLES     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] manual, input logic seq,
                                 input logic [2:0] led_sw, input logic [2:0] pwm);
        bus.sw_manual = manual;
        bus.sw_seq    = seq;
        bus.sw_led    = led_sw;
        bus.pwm_in    = pwm;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pwm"},   8'(bus.pwm_out),   8'd0);
        checkOutput({tag, "_en"},    8'(bus.en_out),    8'd0);
        checkOutput({tag, "_led"},   8'(bus.led),       8'd0);
        checkOutput({tag, "_step"},  8'(bus.step),      8'd0);
        checkOutput({tag, "_state"}, 8'(bus.seq_state), 8'd0);
    endtask

    function automatic logic [2:0] onehot_of(input int s);
        if (s == 0) return 3'b000;
        return 3'(3'b001 << (s - 1));
    endfunction

    // Expected cascade state k cycles after S1 entry: 8-cycle dwell, wrapping S3->S1.
    function automatic int cascade_state(input int k);
        return ((k / 8) % 3) + 1;
    endfunction

    initial begin
        applyStimulus(3'b111, 1'b1, 3'b111, 3'b111);
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");

        applyStimulus(3'b000, 1'b0, 3'b111, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        checkOutput("led_held_through_reset", 8'(bus.led), 8'd0);
        tick(1);
        checkOutput("led_after_full_debounce", 8'(bus.led), 8'h07);
        applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
        tick(7);
        checkOutput("led_release", 8'(bus.led), 8'd0);

        applyStimulus(3'b001, 1'b0, 3'b000, 3'b000);
        tick(6);
        checkOutput("manual_en_early", 8'(bus.en_out), 8'd0);
        tick(1);
        checkOutput("manual_en_7cyc", 8'(bus.en_out), 8'h01);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b001, 1'b0, 3'b000, {2'b11, i[0]});
            tick(1);
            checkOutput("manual_pwm_gate", 8'(bus.pwm_out), 8'({2'b00, i[0]}));
        end
        applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
        tick(7);
        checkOutput("manual_release_en", 8'(bus.en_out), 8'd0);
        checkOutput("manual_release_pwm", 8'(bus.pwm_out), 8'd0);

        applyStimulus(3'b000, 1'b0, 3'b010, 3'b000);
        tick(3);
        applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput("glitch_led", 8'(bus.led), 8'd0);
        end

        applyStimulus(3'b000, 1'b1, 3'b000, 3'b000);
        tick(6);
        checkOutput("casc_pre_state", 8'(bus.seq_state), 8'd0);
        checkOutput("casc_pre_step", 8'(bus.step), 8'd0);
        tick(1);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) tick(1);
            checkOutput("casc_state", 8'(bus.seq_state), 8'(cascade_state(k)));
            checkOutput("casc_step", 8'(bus.step), 8'((k % 8) == 0));
            checkOutput("casc_en", 8'(bus.en_out), 8'((k == 0) ? 3'b000 : onehot_of(cascade_state(k - 1))));
        end

        // Dropped so that IDLE lands exactly on the S2->S3 boundary edge.
        applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
        tick(6);
        checkOutput("abort_still_s2", 8'(bus.seq_state), 8'd2);
        checkOutput("abort_pre_step", 8'(bus.step), 8'd0);
        tick(1);
        checkOutput("abort_idle", 8'(bus.seq_state), 8'd0);
        checkOutput("abort_no_step", 8'(bus.step), 8'd0);
        checkOutput("abort_en_lag", 8'(bus.en_out), 8'h02);
        tick(1);
        checkOutput("abort_en_clear", 8'(bus.en_out), 8'd0);
        checkOutput("abort_step_quiet", 8'(bus.step), 8'd0);

        applyStimulus(3'b100, 1'b1, 3'b000, 3'b111);
        tick(6);
        checkOutput("mixed_pre_state", 8'(bus.seq_state), 8'd0);
        checkOutput("mixed_pre_en", 8'(bus.en_out), 8'd0);
        prev_en = 3'b000;
        tick(1);
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) tick(1);
            exp_en = 3'b100 | ((k == 0) ? 3'b000 : onehot_of(cascade_state(k - 1)));
            checkOutput("mixed_state", 8'(bus.seq_state), 8'(cascade_state(k)));
            checkOutput("mixed_step", 8'(bus.step), 8'((k % 8) == 0));
            checkOutput("mixed_en", 8'(bus.en_out), 8'(exp_en));
            checkOutput("mixed_pwm", 8'(bus.pwm_out), 8'(prev_en));
            checkOutput("mixed_led", 8'(bus.led), 8'd0);
            prev_en = exp_en;
        end

        rst_n = 1'b0;
        #1 checkAllZero("reset_in_s3");
        applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        checkAllZero("after_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/casca_seq.md
CASCA_SEQ -- requirements
Module: casca_seq

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable clk cycles (20 ms at 50 MHz) required to accept a switch change; legal range >= 2.
REQ-002 Parameter STEP_CYCLES, default 100_000_000, is the dwell time in clk cycles of each cascade step (2 s at 50 MHz); legal range >= 2.
REQ-003 clk  input  1  single clock (PLL or 50 MHz board clock); all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sw_manual  input  3  raw board switches, bit i forces shell i on.
REQ-006 sw_seq  input  1  raw board switch enabling the automatic cascade.
REQ-007 sw_led  input  3  raw board switches, bit i lights led[i].
REQ-008 pwm_in  input  3  per-shell PWM from the PWM generator instances.
REQ-009 pwm_out  output  3  gated PWM to the shell drivers.
REQ-010 en_out  output  3  current shell enable mask.
REQ-011 led  output  3  debounced LED drive.
REQ-012 step  output  1  one-cycle pulse on every cascade step change.
REQ-013 seq_state  output  2  cascade state encoding: 0 IDLE, 1 S1, 2 S2, 3 S3.

Function
REQ-014 Every raw switch input (7 bits) SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each synchronized bit SHALL have its own debouncer: a counter incrementing while sync != stable, cleared when sync == stable; when the counter equals DEBOUNCE_CYCLES-1 with a mismatch, stable <= sync and counter <= 0.
REQ-016 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES); it SHALL never wrap.
REQ-017 A pulse on any raw switch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no change in any output.
REQ-018 The cascade FSM SHALL use the debounced sw_seq (seq_db) and a step timer of width $clog2(STEP_CYCLES).
REQ-019 IDLE: timer held at 0; seq_db=1 -> S1 next cycle, timer 0.
REQ-020 S1/S2/S3: timer increments each cycle; at timer == STEP_CYCLES-1 timer <= 0 and state advances S1->S2->S3->S1 (wrap), step pulses for exactly that cycle.
REQ-021 The IDLE->S1 entry SHALL also pulse step; the return to IDLE SHALL NOT.
REQ-022 seq_db=0 in any running state SHALL force IDLE and timer 0 on the next edge, overriding a simultaneous step boundary (no step pulse).
REQ-023 en_out[i] SHALL be registered: manual_db[i] OR (state == S(i+1)); manual and cascade enables combine independently, never clearing each other.
REQ-024 pwm_out[i] SHALL be registered pwm_in[i] AND en_out[i] (en_out value of the same cycle), i.e. 1-cycle latency from pwm_in.
REQ-025 led[i] SHALL be registered led_db[i]; led is independent of cascade state.
REQ-026 Latency from a held raw switch edge to en_out/led change SHALL be 2 + DEBOUNCE_CYCLES + 1 clk cycles (one cycle more for cascade-driven en_out via the state register).
REQ-027 seq_state SHALL reflect the state register directly.

Reset
REQ-028 rst_n low SHALL immediately clear pwm_out, en_out, led, step, seq_state, all synchronizer flops, debounce stable values and counters, and the step timer, independent of clk.
REQ-029 After rst_n release, a switch already held high SHALL be accepted only after the full debounce latency (no bypass).
REQ-030 Reset asserted mid-cascade SHALL restart from IDLE; re-entry SHALL begin at S1 with a full STEP_CYCLES dwell.

Verification (DEBOUNCE_CYCLES=4, STEP_CYCLES=8)
REQ-031 Reset: rst_n low with all switches high -> all outputs 0 immediately; seq_state 0.
REQ-032 Manual: sw_manual=3'b001 held, pwm_in[0] toggling -> en_out=3'b001 exactly 7 cycles after switch edge; pwm_out[0] then equals pwm_in[0] delayed 1 cycle; pwm_out[2:1]=0.
REQ-033 Glitch: sw_led[1] high for 3 cycles -> led stays 3'b000.
REQ-034 Cascade: sw_seq held -> seq_state 1,2,3,1 for 8 cycles each; en_out 001,010,100,001 one cycle after each state change; step pulses at each transition including IDLE->S1.
REQ-035 Abort: sw_seq dropped during S2 -> after debounce seq_state=0, en_out=000, no step pulse; re-assert -> S1 with full 8-cycle dwell.
REQ-036 Mixed: sw_manual=3'b100 held during cascade -> en_out 101,110,100,101; rst_n pulse in S3 -> all outputs 0 asynchronously.
